dpe_demultiplexer: RTL and testbench
====================================

// Module: dpe_demultiplexer
// PURPOSE
//  Egress stage at the tail of the DPE pipeline. Consumes the single merged stream
//  built by the ingress multiplexer and routes each packet whole to one of five
//  egress ports (CPU, ETH_1..ETH_4), selected by tuser_dst. Unroutable packets are
//  dropped and counted. pause/is_idle allow packet-boundary quiescing, as at ingress.
// PARAMETERS
//  DROP_CNT_W   16   width of the saturating drop counter
// PORTS
//  from_dpe.clk   input   1       clock for all logic; all dpe_if ports share it
//  from_dpe.rst   input   1       synchronous, active-high reset
//  pause          input   1       stop accepting new packets at the next packet boundary
//  is_idle        output  1       quiesced: FSM in IDLE and all egress skid buffers empty
//  drop_cnt       output  DROP_CNT_W  count of dropped packets; saturates at all-ones
//  from_dpe       dpe_if.s_axis   merged input stream (tdata/tkeep/tlast/tuser_*)
//  to_cpu         dpe_if.m_axis   egress for DPE_ADDR_CPU
//  to_eth_1..4    dpe_if.m_axis   egress for DPE_ADDR_ETH_1..DPE_ADDR_ETH_4
// BEHAVIOUR
//  Reset: state=IDLE; drop_cnt=0; all egress tvalid=0; from_dpe.tready=0; is_idle=1
//   once the skid buffers are empty (they are empty immediately after reset).
//  FSM states: IDLE, HEAD, FWD, DROP.
//   IDLE: tready=0. If !pause -> HEAD.
//   HEAD: waits for the first beat. from_dpe.tready follows the tready of the selected
//    egress. If tuser_dst is unmatched, tready=1.
//    - If pause && !tvalid -> IDLE.
//    - On tvalid, dst is decoded combinationally and latched into sel_q.
//      - Matched dst: beat is forwarded. tlast=1 -> HEAD (stay in HEAD for
//        single-beat packets); tlast=0 -> FWD.
//      - Unmatched dst: beat is consumed. tlast=1 -> drop_cnt++ and stay in HEAD;
//        tlast=0 -> DROP.
//   FWD: beats go to egress sel_q only; tready = that egress's skid tready.
//    tuser_dst of non-first beats is ignored (the route is fixed per packet).
//    On tvalid&&tready&&tlast -> (pause ? IDLE : HEAD).
//   DROP: tready=1; beats are discarded.
//    On tvalid&&tlast -> drop_cnt++ (saturating), then (pause ? IDLE : HEAD).
//  Egress drive: the selected egress receives tvalid/tdata/tkeep/tlast/tuser_* unchanged
//   (tuser_src preserved). All other egresses are driven with tvalid=0 and data='0.
//  Latency: each egress goes through its own dpe_if_skid_buffer, giving 1 cycle of
//   data latency. Full throughput of 1 beat/clk is sustained while the target egress
//   is ready. A stalled egress back-pressures the input and blocks all ports
//   (head-of-line blocking, by design).
//  pause: takes effect only between packets. A packet in flight always completes.
//   is_idle = (state==IDLE) && !to_cpu.tvalid && !to_eth_1..4.tvalid.
//  Mid-operation reset: FSM returns to IDLE and skid buffers flush. A partial packet is
//   lost; the bench must not expect it on any egress.
//  AXIS rules: no output tvalid may drop without a handshake; output data is stable
//   while tvalid && !tready.
// TESTING
//  1) Reset, pause=0; 3-beat packet dst=DPE_ADDR_ETH_2 with data A,B,C -> to_eth_2 emits
//     A,B,C with tlast on C, 1 cycle after input; other egresses have tvalid=0 throughout.
//  2) Back-to-back 1-beat packets to CPU, ETH_1, ETH_4, all egresses ready -> one beat
//     per clk in and out; each appears only on its port; no bubbles.
//  3) 4-beat packet to ETH_3 with tuser_dst changed to CPU on beat 2 -> all 4 beats on
//     to_eth_3; to_cpu stays idle.
//  4) Packets with unmatched dst (1-beat, then 5-beat) -> no egress tvalid; tready=1;
//     drop_cnt = 1 then 2. Preload drop_cnt to all-ones -> stays all-ones.
//  5) to_eth_1.tready=0 for 10 cycles during a packet to ETH_1 -> from_dpe.tready=0;
//     held data is stable; the stream resumes losslessly when tready returns.
//  6) pause=1 asserted on beat 2 of a 4-beat packet -> packet completes, FSM goes
//     IDLE, is_idle=1 after the skid drains; pause=0 -> next packet accepted.
//     Assert rst mid-packet -> is_idle=1 and drop_cnt=0 after the reset cycle.

Source files
------------

// File: rtl/dpe_demultiplexer.sv
// ---------------------------------------------------------------------------
// dpe_demultiplexer
//
// Purpose:
//   Egress stage at the tail of the DPE pipeline. Takes the single merged
//   AXI-Stream built by the ingress multiplexer and routes each packet, whole,
//   to one of five egress ports (CPU, ETH_1..ETH_4). The route is chosen from
//   tuser_dst of the first beat and then held for the rest of the packet.
//   Packets whose destination matches no port are consumed and counted in a
//   saturating drop counter. pause/is_idle let software quiesce the block on
//   a packet boundary.
//
// Ports:
//   clk, rst                 shared clock, synchronous active-high reset
//   pause                    stop accepting new packets at the next boundary
//   is_idle                  FSM idle and every egress skid buffer empty
//   drop_cnt                 saturating count of dropped packets
//   from_dpe_*               merged input stream (slave side)
//   to_cpu_*, to_eth_N_*     egress streams (master side), one per port
//
// Each egress has its own skid buffer (dpe_if_skid_buffer below), giving one
// cycle of data latency at full throughput.
// ---------------------------------------------------------------------------

// Two-entry skid buffer: a registered output stage plus one overflow slot.
// s_ready depends only on register state, so the upstream ready path is cut
// while still sustaining one beat per clock.
module dpe_if_skid_buffer #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [PW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [PW-1:0] m_data
);

  logic          out_valid_q;
  logic          skid_valid_q;
  logic [PW-1:0] out_data_q;
  logic [PW-1:0] skid_data_q;

  assign s_ready = !skid_valid_q;
  assign m_valid = out_valid_q;
  assign m_data  = out_valid_q ? out_data_q : '0;

  // A new beat goes straight to the output stage when that stage is empty or
  // draining this cycle; otherwise it parks in the skid slot. When no beat
  // arrives, a draining output stage refills from the skid slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else if (s_valid && s_ready) begin
      if (!out_valid_q || m_ready) begin
        out_valid_q <= 1'b1;
        out_data_q  <= s_data;
      end else begin
        skid_valid_q <= 1'b1;
        skid_data_q  <= s_data;
      end
    end else if (m_ready) begin
      out_valid_q  <= skid_valid_q;
      out_data_q   <= skid_data_q;
      skid_valid_q <= 1'b0;
    end
  end

endmodule

module dpe_demultiplexer #(
  parameter int                DATA_W       = 64,
  parameter int                SRC_W        = 4,
  parameter int                DST_W        = 4,
  parameter int                DROP_CNT_W   = 16,
  parameter logic [DST_W-1:0]  DPE_ADDR_CPU   = 'd0,
  parameter logic [DST_W-1:0]  DPE_ADDR_ETH_1 = 'd1,
  parameter logic [DST_W-1:0]  DPE_ADDR_ETH_2 = 'd2,
  parameter logic [DST_W-1:0]  DPE_ADDR_ETH_3 = 'd3,
  parameter logic [DST_W-1:0]  DPE_ADDR_ETH_4 = 'd4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pause,
  output logic                   is_idle,
  output logic [DROP_CNT_W-1:0]  drop_cnt,

  input  logic                   from_dpe_tvalid,
  output logic                   from_dpe_tready,
  input  logic [DATA_W-1:0]      from_dpe_tdata,
  input  logic [DATA_W/8-1:0]    from_dpe_tkeep,
  input  logic                   from_dpe_tlast,
  input  logic [SRC_W-1:0]       from_dpe_tuser_src,
  input  logic [DST_W-1:0]       from_dpe_tuser_dst,

  output logic                   to_cpu_tvalid,
  input  logic                   to_cpu_tready,
  output logic [DATA_W-1:0]      to_cpu_tdata,
  output logic [DATA_W/8-1:0]    to_cpu_tkeep,
  output logic                   to_cpu_tlast,
  output logic [SRC_W-1:0]       to_cpu_tuser_src,
  output logic [DST_W-1:0]       to_cpu_tuser_dst,

  output logic                   to_eth_1_tvalid,
  input  logic                   to_eth_1_tready,
  output logic [DATA_W-1:0]      to_eth_1_tdata,
  output logic [DATA_W/8-1:0]    to_eth_1_tkeep,
  output logic                   to_eth_1_tlast,
  output logic [SRC_W-1:0]       to_eth_1_tuser_src,
  output logic [DST_W-1:0]       to_eth_1_tuser_dst,

  output logic                   to_eth_2_tvalid,
  input  logic                   to_eth_2_tready,
  output logic [DATA_W-1:0]      to_eth_2_tdata,
  output logic [DATA_W/8-1:0]    to_eth_2_tkeep,
  output logic                   to_eth_2_tlast,
  output logic [SRC_W-1:0]       to_eth_2_tuser_src,
  output logic [DST_W-1:0]       to_eth_2_tuser_dst,

  output logic                   to_eth_3_tvalid,
  input  logic                   to_eth_3_tready,
  output logic [DATA_W-1:0]      to_eth_3_tdata,
  output logic [DATA_W/8-1:0]    to_eth_3_tkeep,
  output logic                   to_eth_3_tlast,
  output logic [SRC_W-1:0]       to_eth_3_tuser_src,
  output logic [DST_W-1:0]       to_eth_3_tuser_dst,

  output logic                   to_eth_4_tvalid,
  input  logic                   to_eth_4_tready,
  output logic [DATA_W-1:0]      to_eth_4_tdata,
  output logic [DATA_W/8-1:0]    to_eth_4_tkeep,
  output logic                   to_eth_4_tlast,
  output logic [SRC_W-1:0]       to_eth_4_tuser_src,
  output logic [DST_W-1:0]       to_eth_4_tuser_dst
);

  localparam int KEEP_W  = DATA_W / 8;
  localparam int PW      = DATA_W + KEEP_W + 1 + SRC_W + DST_W;
  localparam int N_PORTS = 5;

  typedef enum logic [1:0] {IDLE, HEAD, FWD, DROP} state_t;

  state_t                state_q;
  state_t                state_d;
  logic [2:0]            sel_q;
  logic [2:0]            dec_idx;
  logic                  dec_hit;
  logic [2:0]            route_idx;
  logic                  route_hit;
  logic                  drop_inc;
  logic [PW-1:0]         in_payload;
  logic [N_PORTS-1:0]    skid_in_valid;
  logic [N_PORTS-1:0]    skid_in_ready;
  logic [PW-1:0]         skid_in_data [N_PORTS];
  logic [N_PORTS-1:0]    eg_valid;
  logic [N_PORTS-1:0]    eg_ready;
  logic [PW-1:0]         eg_data [N_PORTS];

  assign in_payload = {from_dpe_tdata, from_dpe_tkeep, from_dpe_tlast,
                       from_dpe_tuser_src, from_dpe_tuser_dst};

  // Port index 0 is CPU, 1..4 are ETH_1..ETH_4.
  always_comb begin
    dec_hit = 1'b1;
    dec_idx = 3'd0;
    if (from_dpe_tuser_dst == DPE_ADDR_CPU)        dec_idx = 3'd0;
    else if (from_dpe_tuser_dst == DPE_ADDR_ETH_1) dec_idx = 3'd1;
    else if (from_dpe_tuser_dst == DPE_ADDR_ETH_2) dec_idx = 3'd2;
    else if (from_dpe_tuser_dst == DPE_ADDR_ETH_3) dec_idx = 3'd3;
    else if (from_dpe_tuser_dst == DPE_ADDR_ETH_4) dec_idx = 3'd4;
    else                                           dec_hit = 1'b0;
  end

  // The first beat routes on the live decode; later beats use the latched
  // route so a changing tuser_dst mid-packet cannot split the packet.
  always_comb begin
    route_idx     = (state_q == HEAD) ? dec_idx : sel_q;
    route_hit     = (state_q == FWD) || ((state_q == HEAD) && dec_hit);
    skid_in_valid = '0;
    if (route_hit && from_dpe_tvalid) skid_in_valid[route_idx] = 1'b1;
  end

  // Ready back to the merged stream. Dropped beats are always swallowed;
  // routed beats wait on their egress, which blocks every other port too.
  always_comb begin
    from_dpe_tready = 1'b0;
    case (state_q)
      IDLE:    from_dpe_tready = 1'b0;
      HEAD:    from_dpe_tready = dec_hit ? skid_in_ready[dec_idx] : 1'b1;
      FWD:     from_dpe_tready = skid_in_ready[sel_q];
      DROP:    from_dpe_tready = 1'b1;
      default: from_dpe_tready = 1'b0;
    endcase
  end

  // Next-state logic. pause is only honoured between packets: in HEAD when
  // no beat is offered, or right after the last beat of a multi-beat packet.
  always_comb begin
    state_d  = state_q;
    drop_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (!pause) state_d = HEAD;
      end
      HEAD: begin
        if (from_dpe_tvalid) begin
          if (dec_hit) begin
            if (from_dpe_tready && !from_dpe_tlast) state_d = FWD;
          end else if (from_dpe_tlast) begin
            drop_inc = 1'b1;
          end else begin
            state_d = DROP;
          end
        end else if (pause) begin
          state_d = IDLE;
        end
      end
      FWD: begin
        if (from_dpe_tvalid && from_dpe_tready && from_dpe_tlast)
          state_d = pause ? IDLE : HEAD;
      end
      DROP: begin
        if (from_dpe_tvalid && from_dpe_tlast) begin
          drop_inc = 1'b1;
          state_d  = pause ? IDLE : HEAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched route and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= 3'd0;
      drop_cnt <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == HEAD) && from_dpe_tvalid && from_dpe_tready && dec_hit)
        sel_q <= dec_idx;
      if (drop_inc && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_PORTS; i++) begin : g_egress
    assign skid_in_data[i] = skid_in_valid[i] ? in_payload : '0;

    dpe_if_skid_buffer #(.PW(PW)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .s_valid (skid_in_valid[i]),
      .s_ready (skid_in_ready[i]),
      .s_data  (skid_in_data[i]),
      .m_valid (eg_valid[i]),
      .m_ready (eg_ready[i]),
      .m_data  (eg_data[i])
    );
  end

  assign eg_ready = {to_eth_4_tready, to_eth_3_tready, to_eth_2_tready,
                     to_eth_1_tready, to_cpu_tready};

  assign to_cpu_tvalid   = eg_valid[0];
  assign to_eth_1_tvalid = eg_valid[1];
  assign to_eth_2_tvalid = eg_valid[2];
  assign to_eth_3_tvalid = eg_valid[3];
  assign to_eth_4_tvalid = eg_valid[4];

  assign {to_cpu_tdata, to_cpu_tkeep, to_cpu_tlast,
          to_cpu_tuser_src, to_cpu_tuser_dst} = eg_data[0];
  assign {to_eth_1_tdata, to_eth_1_tkeep, to_eth_1_tlast,
          to_eth_1_tuser_src, to_eth_1_tuser_dst} = eg_data[1];
  assign {to_eth_2_tdata, to_eth_2_tkeep, to_eth_2_tlast,
          to_eth_2_tuser_src, to_eth_2_tuser_dst} = eg_data[2];
  assign {to_eth_3_tdata, to_eth_3_tkeep, to_eth_3_tlast,
          to_eth_3_tuser_src, to_eth_3_tuser_dst} = eg_data[3];
  assign {to_eth_4_tdata, to_eth_4_tkeep, to_eth_4_tlast,
          to_eth_4_tuser_src, to_eth_4_tuser_dst} = eg_data[4];

  assign is_idle = (state_q == IDLE) && (eg_valid == '0);

endmodule

// File: tb/tb_dpe_demultiplexer.sv
// ---------------------------------------------------------------------------
// tb_dpe_demultiplexer
//
// Drives packets into dpe_demultiplexer and keeps a packet-level model: each
// packet's beats are expected, in order and unchanged, on the port named by
// its first-beat destination (addresses 0..4 map to CPU, ETH_1..ETH_4; any
// other value is a drop). A negedge monitor records every egress handshake
// and watches for data changing under back-pressure.
// ---------------------------------------------------------------------------
module tb_dpe_demultiplexer;

  localparam int DATA_W  = 32;
  localparam int KEEP_W  = DATA_W / 8;
  localparam int SRC_W   = 4;
  localparam int DST_W   = 4;
  localparam int CNT_W   = 3;
  localparam int PW      = DATA_W + KEEP_W + 1 + SRC_W + DST_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                pause;
  logic                is_idle;
  logic [CNT_W-1:0]    drop_cnt;
  logic                in_tvalid;
  logic                in_tready;
  logic [DATA_W-1:0]   in_tdata;
  logic [KEEP_W-1:0]   in_tkeep;
  logic                in_tlast;
  logic [SRC_W-1:0]    in_src;
  logic [DST_W-1:0]    in_dst;

  logic [4:0]          eg_valid;
  logic [4:0]          eg_ready;
  logic [DATA_W-1:0]   eg_tdata [5];
  logic [KEEP_W-1:0]   eg_tkeep [5];
  logic                eg_tlast [5];
  logic [SRC_W-1:0]    eg_src [5];
  logic [DST_W-1:0]    eg_dst [5];
  logic [PW-1:0]       eg_pay [5];

  int                  checks = 0;
  int                  errors = 0;
  int                  cyc = 0;
  int                  drop_model = 0;
  int                  stab_err = 0;
  int                  vld_cnt [5] = '{0, 0, 0, 0, 0};
  logic [PW-1:0]       exp_q [5][$];
  logic [PW-1:0]       obs_q [5][$];
  int                  obs_cyc [5][$];
  int                  in_cyc [$];
  int                  obs_base [5];
  int                  vld_base [5];
  int                  stab_base;
  logic [4:0]          prev_stall = '0;
  logic [PW-1:0]       prev_pay [5];

  dpe_demultiplexer #(
    .DATA_W(DATA_W), .SRC_W(SRC_W), .DST_W(DST_W), .DROP_CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .pause(pause), .is_idle(is_idle), .drop_cnt(drop_cnt),
    .from_dpe_tvalid(in_tvalid), .from_dpe_tready(in_tready),
    .from_dpe_tdata(in_tdata), .from_dpe_tkeep(in_tkeep), .from_dpe_tlast(in_tlast),
    .from_dpe_tuser_src(in_src), .from_dpe_tuser_dst(in_dst),
    .to_cpu_tvalid(eg_valid[0]), .to_cpu_tready(eg_ready[0]), .to_cpu_tdata(eg_tdata[0]),
    .to_cpu_tkeep(eg_tkeep[0]), .to_cpu_tlast(eg_tlast[0]),
    .to_cpu_tuser_src(eg_src[0]), .to_cpu_tuser_dst(eg_dst[0]),
    .to_eth_1_tvalid(eg_valid[1]), .to_eth_1_tready(eg_ready[1]), .to_eth_1_tdata(eg_tdata[1]),
    .to_eth_1_tkeep(eg_tkeep[1]), .to_eth_1_tlast(eg_tlast[1]),
    .to_eth_1_tuser_src(eg_src[1]), .to_eth_1_tuser_dst(eg_dst[1]),
    .to_eth_2_tvalid(eg_valid[2]), .to_eth_2_tready(eg_ready[2]), .to_eth_2_tdata(eg_tdata[2]),
    .to_eth_2_tkeep(eg_tkeep[2]), .to_eth_2_tlast(eg_tlast[2]),
    .to_eth_2_tuser_src(eg_src[2]), .to_eth_2_tuser_dst(eg_dst[2]),
    .to_eth_3_tvalid(eg_valid[3]), .to_eth_3_tready(eg_ready[3]), .to_eth_3_tdata(eg_tdata[3]),
    .to_eth_3_tkeep(eg_tkeep[3]), .to_eth_3_tlast(eg_tlast[3]),
    .to_eth_3_tuser_src(eg_src[3]), .to_eth_3_tuser_dst(eg_dst[3]),
    .to_eth_4_tvalid(eg_valid[4]), .to_eth_4_tready(eg_ready[4]), .to_eth_4_tdata(eg_tdata[4]),
    .to_eth_4_tkeep(eg_tkeep[4]), .to_eth_4_tlast(eg_tlast[4]),
    .to_eth_4_tuser_src(eg_src[4]), .to_eth_4_tuser_dst(eg_dst[4])
  );

  always_comb begin
    for (int i = 0; i < 5; i++)
      eg_pay[i] = {eg_tdata[i], eg_tkeep[i], eg_tlast[i], eg_src[i], eg_dst[i]};
  end

  // Cycle counter used to timestamp input and output handshakes.
  always @(posedge clk) cyc++;

  // Egress monitor: logs accepted beats and flags any beat that changes or
  // vanishes while it is being held back by its consumer.
  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rst) begin
        prev_stall[i] = 1'b0;
      end else begin
        if (prev_stall[i] && (!eg_valid[i] || eg_pay[i] !== prev_pay[i])) stab_err++;
        if (eg_valid[i]) vld_cnt[i]++;
        if (eg_valid[i] && eg_ready[i]) begin
          obs_q[i].push_back(eg_pay[i]);
          obs_cyc[i].push_back(cyc);
        end
        prev_stall[i] = eg_valid[i] && !eg_ready[i];
        prev_pay[i]   = eg_pay[i];
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  function automatic int route_of(input logic [DST_W-1:0] dst);
    return (dst <= 4) ? int'(dst) : -1;
  endfunction

  task automatic start_test();
    for (int i = 0; i < 5; i++) begin
      obs_base[i] = obs_q[i].size();
      vld_base[i] = vld_cnt[i];
      exp_q[i]    = {};
    end
    in_cyc    = {};
    stab_base = stab_err;
  endtask

  // Sends one packet (or its first stop_after beats). From beat alt_beat on,
  // tuser_dst is replaced by alt_dst; pause is raised on beat pause_beat.
  task automatic send_packet(input logic [DST_W-1:0] dst, input int n, input int stop_after,
                             input int alt_beat, input logic [DST_W-1:0] alt_dst,
                             input int pause_beat, output int acc);
    int route;
    int waited;
    bit hs;
    route = route_of(dst);
    acc   = 0;
    for (int b = 0; b < n && b < stop_after; b++) begin
      in_tvalid = 1'b1;
      in_tdata  = $urandom;
      in_tkeep  = KEEP_W'($urandom);
      in_tlast  = (b == n - 1);
      in_src    = SRC_W'($urandom);
      in_dst    = (alt_beat >= 0 && b >= alt_beat) ? alt_dst : dst;
      if (b == pause_beat) pause = 1'b1;
      waited = 0;
      hs     = 1'b0;
      while (!hs && waited < 200) begin
        @(negedge clk);
        waited++;
        hs = in_tready;
      end
      checks++;
      if (!hs) begin
        errors++;
        $display("[TB] FAIL accept_timeout beat %0d got tready=0 want 1 within 200 cycles", b);
        in_tvalid = 1'b0;
        return;
      end
      acc += waited;
      in_cyc.push_back(cyc);
      if (route >= 0) exp_q[route].push_back({in_tdata, in_tkeep, in_tlast, in_src, in_dst});
      @(posedge clk);
      #1;
    end
    in_tvalid = 1'b0;
    if (route < 0 && stop_after >= n && drop_model < CNT_MAX) drop_model++;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (eg_valid != 5'b0 && n < 100);
    checks++;
    if (eg_valid != 5'b0) begin
      errors++;
      $display("[TB] FAIL drain_timeout got egress valid=%b want 00000", eg_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (is_idle !== 1'b1) begin errors++; $display("[TB] FAIL reset_is_idle got %b want 1", is_idle); end
    checks++;
    if (drop_cnt !== '0) begin errors++; $display("[TB] FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
    checks++;
    if (in_tready !== 1'b0) begin errors++; $display("[TB] FAIL reset_tready got %b want 0", in_tready); end
    checks++;
    if (eg_valid !== 5'b0) begin errors++; $display("[TB] FAIL reset_egress_valid got %b want 00000", eg_valid); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (is_idle !== 1'b0) begin errors++; $display("[TB] FAIL leave_idle got is_idle=%b want 0", is_idle); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_packet();
    int acc;
    start_test();
    send_packet(4'd2, 3, 3, -1, 4'd0, -1, acc);
    wait_drain();
    for (int p = 0; p < 5; p++) begin
      checks++;
      if (obs_q[p].size() - obs_base[p] !== exp_q[p].size() || vld_cnt[p] - vld_base[p] !== exp_q[p].size()) begin
        errors++;
        $display("[TB] FAIL single_count port %0d got %0d beats want %0d", p, obs_q[p].size() - obs_base[p], exp_q[p].size());
      end else begin
        for (int k = 0; k < exp_q[p].size(); k++) begin
          checks++;
          if (obs_q[p][obs_base[p] + k] !== exp_q[p][k]) begin
            errors++;
            $display("[TB] FAIL single_data port %0d beat %0d got %h want %h", p, k, obs_q[p][obs_base[p] + k], exp_q[p][k]);
          end
        end
      end
    end
    for (int k = 0; k < 3 && k < obs_cyc[2].size() - obs_base[2] && k < in_cyc.size(); k++) begin
      checks++;
      if (obs_cyc[2][obs_base[2] + k] !== in_cyc[k] + 1) begin
        errors++;
        $display("[TB] FAIL single_latency beat %0d got cycle %0d want %0d", k, obs_cyc[2][obs_base[2] + k], in_cyc[k] + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    int ports [3] = '{0, 1, 4};
    start_test();
    send_packet(4'd0, 1, 1, -1, 4'd0, -1, acc);
    send_packet(4'd1, 1, 1, -1, 4'd0, -1, acc);
    send_packet(4'd4, 1, 1, -1, 4'd0, -1, acc);
    wait_drain();
    for (int j = 0; j < 3; j++) begin
      int p;
      p = ports[j];
      checks++;
      if (obs_q[p].size() - obs_base[p] !== 1 || in_cyc.size() !== 3) begin
        errors++;
        $display("[TB] FAIL b2b_count port %0d got %0d beats want 1", p, obs_q[p].size() - obs_base[p]);
      end else begin
        checks++;
        if (obs_q[p][obs_base[p]] !== exp_q[p][0] || obs_cyc[p][obs_base[p]] !== in_cyc[j] + 1) begin
          errors++;
          $display("[TB] FAIL b2b_beat port %0d got %h@%0d want %h@%0d", p, obs_q[p][obs_base[p]],
                   obs_cyc[p][obs_base[p]], exp_q[p][0], in_cyc[j] + 1);
        end
        checks++;
        if (in_cyc[j] !== in_cyc[0] + j) begin
          errors++;
          $display("[TB] FAIL b2b_bubble packet %0d got in-cycle %0d want %0d", j, in_cyc[j], in_cyc[0] + j);
        end
      end
    end
    checks++;
    if (obs_q[2].size() - obs_base[2] + obs_q[3].size() - obs_base[3] !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_stray got %0d beats on eth_2/eth_3 want 0", obs_q[2].size() - obs_base[2] + obs_q[3].size() - obs_base[3]);
    end
  endtask

  task automatic test_route_fixed();
    int acc;
    start_test();
    send_packet(4'd3, 4, 4, 1, 4'd0, -1, acc);
    wait_drain();
    for (int p = 0; p < 5; p++) begin
      checks++;
      if (obs_q[p].size() - obs_base[p] !== exp_q[p].size() || vld_cnt[p] - vld_base[p] !== exp_q[p].size()) begin
        errors++;
        $display("[TB] FAIL route_count port %0d got %0d beats want %0d", p, obs_q[p].size() - obs_base[p], exp_q[p].size());
      end else begin
        for (int k = 0; k < exp_q[p].size(); k++) begin
          checks++;
          if (obs_q[p][obs_base[p] + k] !== exp_q[p][k]) begin
            errors++;
            $display("[TB] FAIL route_data port %0d beat %0d got %h want %h", p, k, obs_q[p][obs_base[p] + k], exp_q[p][k]);
          end
        end
      end
    end
  endtask

  task automatic test_drop();
    int acc;
    start_test();
    send_packet(4'd9, 1, 1, -1, 4'd0, -1, acc);
    checks++;
    if (drop_cnt !== CNT_W'(drop_model)) begin errors++; $display("[TB] FAIL drop_one got %0d want %0d", drop_cnt, drop_model); end
    send_packet(4'd12, 5, 5, -1, 4'd0, -1, acc);
    checks++;
    if (drop_cnt !== CNT_W'(drop_model)) begin errors++; $display("[TB] FAIL drop_two got %0d want %0d", drop_cnt, drop_model); end
    checks++;
    if (acc !== 5) begin errors++; $display("[TB] FAIL drop_tready got %0d cycles for 5 beats want 5", acc); end
    for (int i = 0; i < 5; i++) send_packet(4'(5 + i), 1, 1, -1, 4'd0, -1, acc);
    checks++;
    if (drop_cnt !== CNT_W'(drop_model)) begin errors++; $display("[TB] FAIL drop_full got %0d want %0d", drop_cnt, drop_model); end
    send_packet(4'd15, 2, 2, -1, 4'd0, -1, acc);
    checks++;
    if (drop_cnt !== CNT_W'(drop_model)) begin errors++; $display("[TB] FAIL drop_saturate got %0d want %0d", drop_cnt, drop_model); end
    wait_drain();
    checks++;
    if (vld_cnt[0] + vld_cnt[1] + vld_cnt[2] + vld_cnt[3] + vld_cnt[4] !==
        vld_base[0] + vld_base[1] + vld_base[2] + vld_base[3] + vld_base[4]) begin
      errors++;
      $display("[TB] FAIL drop_leak got egress valid cycles during drops want none");
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic stall_tready;
    start_test();
    stall_tready = 1'b1;
    fork
      send_packet(4'd1, 8, 8, -1, 4'd0, -1, acc);
      begin
        repeat (3) @(posedge clk);
        #1;
        eg_ready[1] = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        stall_tready = in_tready;
        @(posedge clk);
        #1;
        eg_ready[1] = 1'b1;
      end
    join
    wait_drain();
    checks++;
    if (stall_tready !== 1'b0) begin errors++; $display("[TB] FAIL stall_tready got %b want 0", stall_tready); end
    checks++;
    if (stab_err !== stab_base) begin errors++; $display("[TB] FAIL stall_stable got %0d violations want 0", stab_err - stab_base); end
    checks++;
    if (obs_q[1].size() - obs_base[1] !== exp_q[1].size()) begin
      errors++;
      $display("[TB] FAIL stall_count got %0d beats want %0d", obs_q[1].size() - obs_base[1], exp_q[1].size());
    end else begin
      for (int k = 0; k < exp_q[1].size(); k++) begin
        checks++;
        if (obs_q[1][obs_base[1] + k] !== exp_q[1][k]) begin
          errors++;
          $display("[TB] FAIL stall_data beat %0d got %h want %h", k, obs_q[1][obs_base[1] + k], exp_q[1][k]);
        end
      end
    end
  endtask

  task automatic test_pause_and_reset();
    int acc;
    int n;
    int taken;
    start_test();
    send_packet(4'd2, 4, 4, -1, 4'd0, 1, acc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (is_idle !== 1'b1 && n < 20);
    checks++;
    if (is_idle !== 1'b1) begin errors++; $display("[TB] FAIL pause_idle got is_idle=%b want 1", is_idle); end
    @(posedge clk);
    #1;
    in_tvalid = 1'b1;
    in_tlast  = 1'b1;
    in_dst    = 4'd3;
    taken = 0;
    repeat (5) begin
      @(negedge clk);
      if (in_tready) taken++;
    end
    checks++;
    if (taken !== 0) begin errors++; $display("[TB] FAIL pause_hold got %0d accepts want 0", taken); end
    checks++;
    if (is_idle !== 1'b1) begin errors++; $display("[TB] FAIL pause_still_idle got %b want 1", is_idle); end
    @(posedge clk);
    #1;
    pause = 1'b0;
    send_packet(4'd4, 1, 1, -1, 4'd0, -1, acc);
    wait_drain();
    for (int p = 0; p < 5; p++) begin
      checks++;
      if (obs_q[p].size() - obs_base[p] !== exp_q[p].size()) begin
        errors++;
        $display("[TB] FAIL pause_count port %0d got %0d beats want %0d", p, obs_q[p].size() - obs_base[p], exp_q[p].size());
      end else begin
        for (int k = 0; k < exp_q[p].size(); k++) begin
          checks++;
          if (obs_q[p][obs_base[p] + k] !== exp_q[p][k]) begin
            errors++;
            $display("[TB] FAIL pause_data port %0d beat %0d got %h want %h", p, k, obs_q[p][obs_base[p] + k], exp_q[p][k]);
          end
        end
      end
    end

    // Abandon a packet halfway and reset; its beats are not expected anywhere.
    send_packet(4'd4, 6, 2, -1, 4'd0, -1, acc);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drop_model = 0;
    @(negedge clk);
    checks++;
    if (is_idle !== 1'b1) begin errors++; $display("[TB] FAIL midreset_idle got %b want 1", is_idle); end
    checks++;
    if (drop_cnt !== '0) begin errors++; $display("[TB] FAIL midreset_drop_cnt got %0d want 0", drop_cnt); end
    @(posedge clk);
    #1;
    start_test();
    send_packet(4'd0, 2, 2, -1, 4'd0, -1, acc);
    wait_drain();
    for (int p = 0; p < 5; p++) begin
      checks++;
      if (obs_q[p].size() - obs_base[p] !== exp_q[p].size()) begin
        errors++;
        $display("[TB] FAIL postreset_count port %0d got %0d beats want %0d", p, obs_q[p].size() - obs_base[p], exp_q[p].size());
      end else begin
        for (int k = 0; k < exp_q[p].size(); k++) begin
          checks++;
          if (obs_q[p][obs_base[p] + k] !== exp_q[p][k]) begin
            errors++;
            $display("[TB] FAIL postreset_data port %0d beat %0d got %h want %h", p, k, obs_q[p][obs_base[p] + k], exp_q[p][k]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int acc;
    bit rnd_done;
    start_test();
    rnd_done = 1'b0;
    fork
      begin
        for (int pk = 0; pk < 40; pk++) begin
          int gap;
          gap = $urandom_range(0, 2);
          repeat (gap) begin
            @(posedge clk);
            #1;
          end
          send_packet(DST_W'($urandom_range(0, 7)), $urandom_range(1, 5), 8, 1,
                      DST_W'($urandom_range(0, 15)), -1, acc);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          for (int i = 0; i < 5; i++) eg_ready[i] = ($urandom_range(0, 3) != 0);
        end
      end
    join
    eg_ready = 5'b11111;
    wait_drain();
    checks++;
    if (drop_cnt !== CNT_W'(drop_model)) begin errors++; $display("[TB] FAIL random_drop got %0d want %0d", drop_cnt, drop_model); end
    checks++;
    if (stab_err !== stab_base) begin errors++; $display("[TB] FAIL random_stable got %0d violations want 0", stab_err - stab_base); end
    for (int p = 0; p < 5; p++) begin
      checks++;
      if (obs_q[p].size() - obs_base[p] !== exp_q[p].size()) begin
        errors++;
        $display("[TB] FAIL random_count port %0d got %0d beats want %0d", p, obs_q[p].size() - obs_base[p], exp_q[p].size());
      end else begin
        for (int k = 0; k < exp_q[p].size(); k++) begin
          checks++;
          if (obs_q[p][obs_base[p] + k] !== exp_q[p][k]) begin
            errors++;
            $display("[TB] FAIL random_data port %0d beat %0d got %h want %h", p, k, obs_q[p][obs_base[p] + k], exp_q[p][k]);
          end
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    pause     = 1'b0;
    in_tvalid = 1'b0;
    in_tdata  = '0;
    in_tkeep  = '0;
    in_tlast  = 1'b0;
    in_src    = '0;
    in_dst    = '0;
    eg_ready  = 5'b11111;
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_route_fixed();
    test_drop();
    test_backpressure();
    test_pause_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
